dm_stage_lsu: RTL and testbench
===============================

Name: dm_stage_lsu

Overview:
Data-memory stage load/store unit of the MIPS32 pipeline. It sits between the EX/DM pipeline register and the DM/WB pipeline register.
- Converts EX/DM memory requests into a req/ready transaction on the data-memory port.
- Aligns and extends load data, and generates store byte enables.
- Drives regfile_data_w into DM/WB.
- Drives dm_stall, which freezes the upstream stages and deasserts the DM/WB enable while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 16, maximum ACCESS-state cycles before abort (used only with DM_TIMEOUT_EN).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-high reset. Asserted = 1 despite the name.
valid_ex_dm  in  1  EX/DM holds a live instruction.
mem_r_en_ex_dm  in  1  load.
mem_w_en_ex_dm  in  1  store.
mem_size_ex_dm  in  2  00 byte, 01 half, 10 word; 11 treated as word.
mem_unsigned_ex_dm  in  1  zero-extend loads (LBU/LHU).
alu_result_ex_dm  in  32  effective address, or the ALU result for non-memory ops.
mem_data_w_ex_dm  in  32  store data (rt).
dmem_req  out  1  memory request, registered.
dmem_we  out  1  1 = write.
dmem_addr  out  32  word address; bits [1:0] forced to 0.
dmem_be  out  4  byte enables; bit i = byte lane i, little-endian.
dmem_wdata  out  32  lane-replicated store data.
dmem_ready  in  1  completes the access in the same cycle it is high during ACCESS.
dmem_rdata  in  32  read data, valid with dmem_ready.
regfile_data_w  out  32  write-back data to DM/WB.
dm_stall  out  1  1 = hold EX/DM and earlier stages, and hold DM/WB.
misalign_exc  out  1  one-cycle flag for a misaligned access.
bus_err  out  1  timeout flag; exists only with DM_TIMEOUT_EN.

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- Reset: state=IDLE. dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, load register=0, bus_err=0. Effect is immediate (asynchronous).
- Combinational outputs are evaluated in IDLE with inputs low during reset, giving regfile_data_w=0, dm_stall=0, misalign_exc=0.
- mem_op = valid & (mem_r_en | mem_w_en).
- Misaligned condition:
  - half with addr[0]=1, or
  - word with addr[1:0]!=0.
- IDLE, no mem_op:
  - regfile_data_w = alu_result_ex_dm; dm_stall=0.
  - Zero added latency.
- IDLE, mem_op misaligned:
  - No memory access; misalign_exc=1 for that cycle.
  - dm_stall=0; regfile_data_w = alu_result_ex_dm.
  - Instruction retires as a NOP-equivalent. Suppressing its write enable is the control unit's job.
- IDLE, mem_op aligned:
  - dm_stall=1.
  - At the clock edge, register dmem_req=1, dmem_we=mem_w_en, dmem_addr={addr[31:2],2'b00}, dmem_be, dmem_wdata; go to ACCESS.
  - If mem_r_en and mem_w_en are both set, the store is performed and the read is ignored.
- Store enables and data:
  - byte: be = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - word: be = 1111; wdata = data.
- Load enables: dmem_be reflects the lanes being read; dmem_wdata=0.
- ACCESS:
  - dm_stall=1; dmem_* held stable.
  - On dmem_ready=1: capture dmem_rdata into the load register; dmem_req=0 at the edge; go to DONE.
  - Ready in the first ACCESS cycle is legal.
- DONE:
  - dm_stall=0.
  - For loads: regfile_data_w = extracted lane, sign-extended, or zero-extended if mem_unsigned.
    - byte: lane addr[1:0].
    - half: lane addr[1].
  - For stores: regfile_data_w = alu_result_ex_dm.
  - Always go to IDLE next cycle.
- Minimum memory-op latency is 3 cycles: IDLE + 1 ACCESS + DONE. Each additional cycle with dmem_ready low adds 1.
- dmem_ready outside ACCESS is ignored.
- Reset mid-ACCESS: dmem_req drops asynchronously and the captured state is discarded.

Optional Feature:
DM_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES: dmem_req=0, load register=0, bus_err=1 for the single DONE cycle, then go to DONE.
  - A ready arriving in the same cycle as the timeout wins.
- Undefined: no counter and no bus_err port; ACCESS waits indefinitely.

Test Plan:
- Non-memory op, alu_result=0x12345678 -> same-cycle regfile_data_w=0x12345678, dm_stall=0, dmem_req never 1.
- SW addr=0x100 data=0xDEADBEEF, ready on first ACCESS cycle -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, dm_stall high exactly 2 cycles.
- SB addr=0x203 data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, dmem_addr=0x200.
- LB addr=0x7 with rdata=0x80FF1234, ready after 3 wait cycles -> regfile_data_w=0xFFFFFF80 in DONE. Same access as LBU -> 0x00000080. dm_stall high 5 cycles.
- LH addr=0x5 -> misalign_exc=1 for one cycle, dm_stall=0, no dmem_req.
- rst_n pulsed mid-ACCESS -> dmem_req=0 immediately, state IDLE. With DM_TIMEOUT_EN and ready held low 16 cycles -> bus_err=1, regfile_data_w=0.

Source files
------------

// File: rtl/dm_stage_lsu.sv
// MIPS32 data-memory stage LSU: EX/DM request -> dmem req/ready, load align/extend, store lane enables.
// Latency: non-memory ops 0 added cycles; memory ops IDLE + >=1 ACCESS + DONE (3 cycles minimum).
// Backpressure: dm_stall holds upstream and DM/WB until DONE; `define DM_TIMEOUT_EN bounds ACCESS and adds bus_err.
module dm_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_ex_dm,
    input  logic        mem_r_en_ex_dm,
    input  logic        mem_w_en_ex_dm,
    input  logic [1:0]  mem_size_ex_dm,
    input  logic        mem_unsigned_ex_dm,
    input  logic [31:0] alu_result_ex_dm,
    input  logic [31:0] mem_data_w_ex_dm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] regfile_data_w,
    output logic        dm_stall,
    output logic        misalign_exc
`ifdef DM_TIMEOUT_EN
    ,
    output logic        bus_err
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] ld_q;
    logic        mem_op, misalign, go, is_load, tmo_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign mem_op   = valid_ex_dm & (mem_r_en_ex_dm | mem_w_en_ex_dm);
    assign misalign = ((mem_size_ex_dm == 2'b01) & alu_result_ex_dm[0]) |
                      (mem_size_ex_dm[1] & (alu_result_ex_dm[1:0] != 2'b00));
    assign go       = mem_op & ~misalign;
    // A simultaneous read and write is treated as a store.
    assign is_load  = mem_r_en_ex_dm & ~mem_w_en_ex_dm;

`ifdef DM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q;

    assign tmo_hit = (state_q == ACCESS) && !dmem_ready && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tmo_cnt_q <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (state_q == IDLE)
                tmo_cnt_q <= '0;
            else if (state_q == ACCESS && !dmem_ready)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_hit)
                bus_err <= 1'b1;
            else if (state_q == DONE)
                bus_err <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = mem_data_w_ex_dm;
        case (mem_size_ex_dm)
            2'b00: begin
                be_d    = 4'b0001 << alu_result_ex_dm[1:0];
                wdata_d = {4{mem_data_w_ex_dm[7:0]}};
            end
            2'b01: begin
                be_d    = alu_result_ex_dm[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{mem_data_w_ex_dm[15:0]}};
            end
            default: ;
        endcase
        if (!mem_w_en_ex_dm)
            wdata_d = '0;
    end

    // EX/DM is frozen by dm_stall, so its size/address still describe the load during DONE.
    always_comb begin
        ld_byte = ld_q[{alu_result_ex_dm[1:0], 3'b000} +: 8];
        ld_half = alu_result_ex_dm[1] ? ld_q[31:16] : ld_q[15:0];
        case (mem_size_ex_dm)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~mem_unsigned_ex_dm}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~mem_unsigned_ex_dm}}, ld_half};
            default: ld_ext = ld_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = ACCESS;
            ACCESS:  if (dmem_ready || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dm_stall       = ((state_q == IDLE) && go) || (state_q == ACCESS);
        misalign_exc   = (state_q == IDLE) && mem_op && misalign;
        regfile_data_w = ((state_q == DONE) && is_load) ? ld_ext : alu_result_ex_dm;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            ld_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_w_en_ex_dm;
                    dmem_addr  <= {alu_result_ex_dm[31:2], 2'b00};
                    dmem_be    <= be_d;
                    dmem_wdata <= wdata_d;
                end
                ACCESS: if (dmem_ready) begin
                    dmem_req <= 1'b0;
                    ld_q     <= dmem_rdata;
                end else if (tmo_hit) begin
                    dmem_req <= 1'b0;
                    ld_q     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_stage_lsu.sv
// Scoreboard bench for dm_stage_lsu: expected transactions queued at issue, compared at ACCESS and DONE.
module tb_dm_stage_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ex_dm, mem_r_en_ex_dm, mem_w_en_ex_dm, mem_unsigned_ex_dm;
    logic [1:0]  mem_size_ex_dm;
    logic [31:0] alu_result_ex_dm, mem_data_w_ex_dm;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, regfile_data_w;
    logic [3:0]  dmem_be;
    logic        dm_stall, misalign_exc;
`ifdef DM_TIMEOUT_EN
    logic        bus_err;
`endif

    typedef struct {
        logic [31:0] wb;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dm_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_ex_dm(valid_ex_dm), .mem_r_en_ex_dm(mem_r_en_ex_dm), .mem_w_en_ex_dm(mem_w_en_ex_dm),
        .mem_size_ex_dm(mem_size_ex_dm), .mem_unsigned_ex_dm(mem_unsigned_ex_dm),
        .alu_result_ex_dm(alu_result_ex_dm), .mem_data_w_ex_dm(mem_data_w_ex_dm),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .regfile_data_w(regfile_data_w), .dm_stall(dm_stall), .misalign_exc(misalign_exc)
`ifdef DM_TIMEOUT_EN
        , .bus_err(bus_err)
`endif
    );

    function automatic logic model_misalign(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b01) return a[0];
        if (sz[1]) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a[1:0];
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        case (sz)
            2'b00: begin
                sh = rd >> (8 * a[1:0]);
                return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh = a[1] ? (rd >> 16) : rd;
                return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: return rd;
        endcase
    endfunction

    task automatic clear_inputs();
        valid_ex_dm = 0; mem_r_en_ex_dm = 0; mem_w_en_ex_dm = 0; mem_unsigned_ex_dm = 0;
        mem_size_ex_dm = 0; alu_result_ex_dm = 0; mem_data_w_ex_dm = 0;
        dmem_ready = 0; dmem_rdata = 0;
    endtask

    // Issues one EX/DM instruction; waits = ACCESS cycles with ready low before ready is given.
    task automatic run_op(input string name, input logic r, input logic w, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int waits, input int exp_stall);
        exp_t        e;
        logic        mis;
        logic [31:0] rd_eff;
        int          stall;
        int          acc;
        bit          done;
        mis    = model_misalign(sz, addr);
        rd_eff = rdata;
`ifdef DM_TIMEOUT_EN
        if (waits >= TMO) rd_eff = 32'h0;
`endif
        e.we    = w;
        e.addr  = {addr[31:2], 2'b00};
        e.be    = model_be(sz, addr);
        e.wdata = w ? model_wdata(sz, data) : 32'h0;
        e.wb    = (r && !w && !mis) ? model_load(sz, uns, addr, rd_eff) : addr;
        if (!mis) exp_q.push_back(e);

        @(negedge clk);
        valid_ex_dm = 1; mem_r_en_ex_dm = r; mem_w_en_ex_dm = w; mem_size_ex_dm = sz;
        mem_unsigned_ex_dm = uns; alu_result_ex_dm = addr; mem_data_w_ex_dm = data;
        dmem_ready = 0; dmem_rdata = rdata;
        stall = 0; acc = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            #2;
            if (dm_stall) stall++;
            if (mis) begin
                n_checks++;
                if (misalign_exc !== 1'b1 || dm_stall !== 1'b0 || dmem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s misalign: exc=%b stall=%b req=%b, required exc=1 stall=0 req=0",
                             name, misalign_exc, dm_stall, dmem_req);
                end
                n_checks++;
                if (regfile_data_w !== addr) begin
                    n_fail++;
                    $display("FAIL %s misalign wb: got %h required %h", name, regfile_data_w, addr);
                end
                done = 1;
            end else if (dmem_req) begin
                if (acc == 0) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s req: unexpected request, scoreboard empty", name);
                    end else if (dmem_we !== exp_q[0].we || dmem_addr !== exp_q[0].addr ||
                                 dmem_be !== exp_q[0].be || dmem_wdata !== exp_q[0].wdata) begin
                        n_fail++;
                        $display("FAIL %s req: we=%b addr=%h be=%b wdata=%h, required we=%b addr=%h be=%b wdata=%h",
                                 name, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                                 exp_q[0].we, exp_q[0].addr, exp_q[0].be, exp_q[0].wdata);
                    end
                end
                dmem_ready = (acc == waits);
                acc++;
            end else if (c > 0) begin
                dmem_ready = 0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s wb: completion with empty scoreboard", name);
                end else begin
                    e = exp_q.pop_front();
                    if (regfile_data_w !== e.wb) begin
                        n_fail++;
                        $display("FAIL %s wb: got %h required %h", name, regfile_data_w, e.wb);
                    end
                end
                n_checks++;
                if (stall != exp_stall) begin
                    n_fail++;
                    $display("FAIL %s stall_cycles: got %0d required %0d", name, stall, exp_stall);
                end
`ifdef DM_TIMEOUT_EN
                n_checks++;
                if (bus_err !== (waits >= TMO)) begin
                    n_fail++;
                    $display("FAIL %s bus_err: got %b required %b", name, bus_err, waits >= TMO);
                end
`endif
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        clear_inputs();
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s completion: no DONE within cycle budget", name);
        end
        if (mis) begin
            @(negedge clk);
            #2;
            n_checks++;
            if (dmem_req !== 1'b0 || misalign_exc !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after_misalign: req=%b exc=%b required 0 0", name, dmem_req, misalign_exc);
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1;
        #2;
        n_checks++;
        if (dmem_req !== 0 || dmem_we !== 0 || dmem_addr !== 0 || dmem_be !== 0 || dmem_wdata !== 0 ||
            regfile_data_w !== 0 || dm_stall !== 0 || misalign_exc !== 0) begin
            n_fail++;
            $display("FAIL reset: req=%b we=%b addr=%h be=%b wdata=%h wb=%h stall=%b exc=%b, required all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, regfile_data_w, dm_stall, misalign_exc);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
    endtask

    task automatic test_non_mem();
        @(negedge clk);
        valid_ex_dm = 1; alu_result_ex_dm = 32'h12345678;
        dmem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if (regfile_data_w !== 32'h12345678 || dm_stall !== 0 || dmem_req !== 0) begin
                n_fail++;
                $display("FAIL non_mem[%0d]: wb=%h stall=%b req=%b, required 12345678 0 0",
                         i, regfile_data_w, dm_stall, dmem_req);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_stores();
        run_op("sw_0x100", 0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2);
        run_op("sb_0x203", 0, 1, 2'b00, 0, 32'h203, 32'h000000A5, 32'h0, 0, 2);
        run_op("sh_0x206", 0, 1, 2'b01, 0, 32'h206, 32'h0000BEEF, 32'h0, 1, 3);
        run_op("rw_both",  1, 1, 2'b11, 0, 32'h40C, 32'h01020304, 32'hFFFFFFFF, 0, 2);
    endtask

    task automatic test_loads();
        run_op("lb_0x7",  1, 0, 2'b00, 0, 32'h7, 32'h0, 32'h80FF1234, 3, 5);
        run_op("lbu_0x7", 1, 0, 2'b00, 1, 32'h7, 32'h0, 32'h80FF1234, 3, 5);
        run_op("lh_0x6",  1, 0, 2'b01, 0, 32'h6, 32'h0, 32'h80FF1234, 0, 2);
        run_op("lhu_0x4", 1, 0, 2'b01, 1, 32'h4, 32'h0, 32'h80FF9234, 2, 4);
        run_op("lw_0x10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hCAFEF00D, 1, 3);
    endtask

    task automatic test_misalign();
        run_op("lh_0x5", 1, 0, 2'b01, 0, 32'h5, 32'h0, 32'h0, 0, 0);
        run_op("sw_0x2", 0, 1, 2'b10, 0, 32'h2, 32'h11223344, 32'h0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] a;
        logic        w;
        int          wt;
        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            w  = 1'($urandom_range(0, 1));
            wt = $urandom_range(0, 4);
            run_op("rand", !w, w, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, wt, 2 + wt);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        valid_ex_dm = 1; mem_r_en_ex_dm = 1; mem_size_ex_dm = 2'b10; alu_result_ex_dm = 32'h40;
        @(negedge clk);
        #2;
        n_checks++;
        if (dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid setup: req=%b required 1", dmem_req);
        end
        clear_inputs();
        rst_n = 1;
        #1;
        n_checks++;
        if (dmem_req !== 0 || dmem_be !== 0 || dm_stall !== 0) begin
            n_fail++;
            $display("FAIL rst_mid immediate: req=%b be=%b stall=%b required 0 0 0", dmem_req, dmem_be, dm_stall);
        end
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        #2;
        n_checks++;
        if (dmem_req !== 0 || dm_stall !== 0) begin
            n_fail++;
            $display("FAIL rst_mid idle: req=%b stall=%b required 0 0", dmem_req, dm_stall);
        end
    endtask

`ifdef DM_TIMEOUT_EN
    task automatic test_timeout();
        run_op("lw_timeout", 1, 0, 2'b10, 0, 32'h80, 32'h0, 32'h55AA55AA, 1000, 1 + TMO);
        run_op("lw_ready_at_limit", 1, 0, 2'b10, 0, 32'h84, 32'h0, 32'h13572468, TMO - 1, TMO + 1);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_non_mem();
        test_stores();
        test_loads();
        test_misalign();
        test_back_to_back();
        test_reset_mid_access();
`ifdef DM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
